video_line_fetcher: RTL and testbench

- Upstream pixel source for the DVI video controller.
- Fetches one scanline of XRGB8888 pixels per line from the framebuffer over a burst read port into a ping-pong line buffer.
- Serves pixels by x index to the colour stage that drives the TMDS encoders.
- Runs entirely in the pixel clock domain; the memory port is a pixel-domain shim.

---
 rtl/video_pkg.sv | 18 +
 rtl/video_line_fetcher_if.sv | 29 ++
 rtl/line_buffer_ram.sv | 25 ++
 rtl/video_line_fetcher.sv | 172 +++++++++++++++++
 tb/tb_video_line_fetcher.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/video_pkg.sv
// Shared video types: pixel format, line-fetch state encoding and the
// per-mode line widths that the video controller also uses.
package video_pkg;

  typedef logic [23:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DATA,
    DRAIN
  } fetch_state_e;

  localparam int unsigned MODE_640_H_PIXELS  = 640;
  localparam int unsigned MODE_800_H_PIXELS  = 800;
  localparam int unsigned MODE_1280_H_PIXELS = 1280;

endpackage

// File: rtl/video_line_fetcher_if.sv
// Memory burst-read port and pixel read port of the line fetcher.
interface video_line_fetcher_if #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned H_PIXELS = 640
);
  import video_pkg::*;

  localparam int unsigned XW = $clog2(H_PIXELS);

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;
  logic              pix_rd;
  logic [XW-1:0]     pix_x;
  pixel_t            pix_data;

  modport master (
    output mem_req, mem_addr, pix_data,
    input  mem_ready, mem_rvalid, mem_rdata, pix_rd, pix_x
  );

  modport slave (
    input  mem_req, mem_addr, pix_data,
    output mem_ready, mem_rvalid, mem_rdata, pix_rd, pix_x
  );

endinterface

// File: rtl/line_buffer_ram.sv
// One scanline buffer: single write port, registered read port.
module line_buffer_ram
  import video_pkg::*;
#(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  pixel_t        wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output pixel_t        rdata
);

  pixel_t mem [DEPTH];

  // Write on we; read data registered and held while re is low.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/video_line_fetcher.sv
// Fetches one scanline per line_start into the back half of a ping-pong
// line buffer and serves pixels from the front half.
module video_line_fetcher
  import video_pkg::*;
#(
  parameter int unsigned H_PIXELS = MODE_640_H_PIXELS,
  parameter int unsigned BURST    = 8,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] fb_base,
  input  logic              line_start,
  input  logic [9:0]        line_num,
  output logic              underrun,
  input  logic              underrun_clr,
  video_line_fetcher_if.master bus
);

  localparam int unsigned XW = $clog2(H_PIXELS);
  localparam int unsigned FW = XW + 1;
  localparam int unsigned BW = $clog2(BURST);
  localparam int unsigned IW = $clog2(H_PIXELS / BURST) + 1;
  localparam int unsigned SH = $clog2(BURST * 4);
  localparam logic [FW-1:0]     FULL       = FW'(H_PIXELS);
  localparam logic [FW-1:0]     FULL_M1    = FW'(H_PIXELS - 1);
  localparam logic [BW-1:0]     LAST_BEAT  = BW'(BURST - 1);
  localparam logic [ADDR_W-1:0] LINE_BYTES = ADDR_W'(H_PIXELS * 4);

  fetch_state_e          state_q, state_d;
  logic                  front_q, front_d;
  logic [1:0][FW-1:0]    fill_q, fill_d;
  logic [ADDR_W-1:0]     line_addr_q, line_addr_d;
  logic [IW-1:0]         burst_idx_q, burst_idx_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic                  underrun_q, underrun_d;
  logic                  rd_valid_q, rd_sel_q;
  logic                  back, ls_go, last_beat, wr_en;
  pixel_t                rdata0, rdata1;
  logic                  unused_rdata_hi;

  assign back      = ~front_q;
  assign ls_go     = line_start & enable;
  assign last_beat = bus.mem_rvalid & (beat_q == LAST_BEAT);

  assign bus.mem_req  = (state_q == REQ);
  assign bus.mem_addr = line_addr_q + (ADDR_W'(burst_idx_q) << SH);
  assign underrun     = underrun_q;
  assign unused_rdata_hi = ^bus.mem_rdata[31:24];

  // Fetch state and buffer bookkeeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      front_q     <= 1'b0;
      fill_q      <= '0;
      line_addr_q <= '0;
      burst_idx_q <= '0;
      beat_q      <= '0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      front_q     <= front_d;
      fill_q      <= fill_d;
      line_addr_q <= line_addr_d;
      burst_idx_q <= burst_idx_d;
      beat_q      <= beat_d;
      underrun_q  <= underrun_d;
    end
  end

  // Next-state: burst sequencing first, then line_start overrides it.
  always_comb begin
    state_d     = state_q;
    front_d     = front_q;
    fill_d      = fill_q;
    line_addr_d = line_addr_q;
    burst_idx_d = burst_idx_q;
    beat_d      = beat_q;
    underrun_d  = underrun_q;
    wr_en       = 1'b0;

    if (underrun_clr) underrun_d = 1'b0;

    case (state_q)
      IDLE: ;
      REQ: begin
        if (bus.mem_ready) begin
          state_d = DATA;
          beat_d  = '0;
        end
      end
      DATA: begin
        if (bus.mem_rvalid) begin
          beat_d = beat_q + 1'b1;
          // A beat coinciding with line_start belongs to the old line: drop it.
          if (fill_q[back] != FULL && !line_start) begin
            wr_en        = 1'b1;
            fill_d[back] = fill_q[back] + 1'b1;
          end
          if (last_beat) begin
            if (fill_q[back] >= FULL_M1) begin
              state_d = IDLE;
            end else begin
              burst_idx_d = burst_idx_q + 1'b1;
              state_d     = REQ;
            end
          end
        end
      end
      DRAIN: begin
        if (bus.mem_rvalid) begin
          beat_d = beat_q + 1'b1;
          if (last_beat) state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    if (ls_go) begin
      front_d         = ~front_q;
      fill_d[front_q] = '0;
      line_addr_d     = fb_base + ADDR_W'(line_num) * LINE_BYTES;
      burst_idx_d     = '0;
      if (state_q == IDLE) begin
        state_d = REQ;
      end else begin
        underrun_d = 1'b1;
        // Drain only if a burst is outstanding after this edge.
        if (state_q == REQ) state_d = bus.mem_ready ? DRAIN : REQ;
        else                state_d = last_beat ? REQ : DRAIN;
      end
    end else if (line_start) begin
      fill_d = '0;
    end
  end

  // Pixel read qualifier and buffer select, captured with the read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_sel_q   <= 1'b0;
    end else if (bus.pix_rd) begin
      rd_valid_q <= enable & ({1'b0, bus.pix_x} < fill_q[front_q]);
      rd_sel_q   <= front_q;
    end
  end

  assign bus.pix_data = rd_valid_q ? (rd_sel_q ? rdata1 : rdata0) : '0;

  line_buffer_ram #(.DEPTH(H_PIXELS)) u_buf0 (
    .clk   (clk),
    .we    (wr_en & ~back),
    .waddr (fill_q[back][XW-1:0]),
    .wdata (bus.mem_rdata[23:0]),
    .re    (bus.pix_rd),
    .raddr (bus.pix_x),
    .rdata (rdata0)
  );

  line_buffer_ram #(.DEPTH(H_PIXELS)) u_buf1 (
    .clk   (clk),
    .we    (wr_en & back),
    .waddr (fill_q[back][XW-1:0]),
    .wdata (bus.mem_rdata[23:0]),
    .re    (bus.pix_rd),
    .raddr (bus.pix_x),
    .rdata (rdata1)
  );

endmodule

// File: tb/tb_video_line_fetcher.sv
// Directed bench for video_line_fetcher (640 pixels, burst 8, 32-bit address).
module tb_video_line_fetcher;

  localparam int unsigned H = 640;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        line_start = 1'b0;
  logic        underrun_clr = 1'b0;
  logic [31:0] fb_base = '0;
  logic [9:0]  line_num = '0;
  logic        underrun;

  int n_checks = 0;
  int n_pass   = 0;

  video_line_fetcher_if #(.ADDR_W(32), .H_PIXELS(H)) bus ();

  video_line_fetcher #(.H_PIXELS(H), .BURST(8), .ADDR_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .fb_base      (fb_base),
    .line_start   (line_start),
    .line_num     (line_num),
    .underrun     (underrun),
    .underrun_clr (underrun_clr),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic pulse_ls(input logic [9:0] num, input logic [31:0] base);
    line_num = num;
    fb_base = base;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic read_pix(input logic [9:0] x, output logic [23:0] v);
    bus.pix_rd = 1'b1;
    bus.pix_x = x;
    tick();
    bus.pix_rd = 1'b0;
    v = bus.pix_data;
  endtask

  task automatic beat(input logic [23:0] v);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata = {8'hA5, v};
    tick();
    bus.mem_rvalid = 1'b0;
  endtask

  task automatic serve_burst(input logic [31:0] exp_addr, input logic [23:0] v0, input int delay,
                             input bit gapped, inout logic [31:0] last_addr, inout int errs);
    int t;
    t = 0;
    while (bus.mem_req !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== exp_addr) errs++;
    last_addr = bus.mem_addr;
    for (int d = 0; d < delay; d++) begin
      tick();
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== exp_addr) errs++;
    end
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (gapped && (((i * 5) + int'(v0[3:0])) % 3 == 0)) tick();
      beat(v0 + 24'(i));
    end
  endtask

  task automatic fetch_line(input logic [31:0] base, input logic [23:0] seed, input int delay,
                            input bit gapped, output logic [31:0] last_addr, output int errs);
    errs = 0;
    last_addr = '0;
    for (int b = 0; b < 80; b++)
      serve_burst(base + 32'(b * 32), seed + 24'(b * 8), delay, gapped, last_addr, errs);
  endtask

  task automatic check_line(input string tag, input logic [23:0] seed);
    int errs;
    logic [23:0] v;
    errs = 0;
    for (int x = 0; x < int'(H); x++) begin
      read_pix(10'(x), v);
      if (v !== seed + 24'(x)) errs++;
    end
    check(tag, 32'(errs), 32'd0);
  endtask

  initial begin
    int errs;
    int cnt;
    logic [31:0] last;
    logic [23:0] v;

    bus.mem_ready = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0;
    bus.pix_rd = 1'b0;
    bus.pix_x = '0;

    // Reset state
    tick();
    tick();
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_pix_data", 32'(bus.pix_data), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    reset = 1'b0;
    enable = 1'b1;
    tick();

    // Basic fetch of line 0 at fb_base 0x1000
    pulse_ls(10'd0, 32'h1000);
    check("l0_first_req", 32'(bus.mem_req), 32'd1);
    check("l0_first_addr", bus.mem_addr, 32'h1000);
    fetch_line(32'h1000, 24'h000000, 0, 1'b0, last, errs);
    check("l0_burst_errs", 32'(errs), 32'd0);
    check("l0_last_addr", last, 32'h19E0);
    check("l0_idle_req", 32'(bus.mem_req), 32'd0);
    read_pix(10'd5, v);
    check("preswap_pix5", 32'(v), 32'd0);

    // Swap; request line 3 at fb_base 0
    pulse_ls(10'd3, 32'h0);
    check("l3_first_addr", bus.mem_addr, 32'h1E00);
    check("l3_underrun", 32'(underrun), 32'd0);
    read_pix(10'd5, v);
    check("l0_pix5", 32'(v), 32'h000005);
    check_line("l0_contents", 24'h000000);

    // Back-pressure and gapped beats on line 3
    fetch_line(32'h1E00, 24'h300000, 7, 1'b1, last, errs);
    check("l3_burst_errs", 32'(errs), 32'd0);
    check("l3_last_addr", last, 32'h27E0);
    pulse_ls(10'd4, 32'h0);
    check_line("l3_contents", 24'h300000);

    // Abort line 4 after 2 bursts + 3 beats
    errs = 0;
    serve_burst(32'h2800, 24'h400000, 0, 1'b0, last, errs);
    serve_burst(32'h2820, 24'h400008, 0, 1'b0, last, errs);
    check("l4_burst_errs", 32'(errs), 32'd0);
    check("l4_b2_addr", bus.mem_addr, 32'h2840);
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) beat(24'h400010 + 24'(i));
    pulse_ls(10'd7, 32'h0);
    check("abort_underrun", 32'(underrun), 32'd1);
    check("drain_no_req", 32'(bus.mem_req), 32'd0);
    for (int i = 0; i < 4; i++) beat(24'hDEAD00 + 24'(i));
    check("drain_4_no_req", 32'(bus.mem_req), 32'd0);
    beat(24'hDEAD04);
    check("l7_req", 32'(bus.mem_req), 32'd1);
    check("l7_addr", bus.mem_addr, 32'h4600);
    read_pix(10'd18, v);
    check("partial_pix18", 32'(v), 32'h400012);
    read_pix(10'd19, v);
    check("partial_pix19", 32'(v), 32'd0);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    check("underrun_cleared", 32'(underrun), 32'd0);
    fetch_line(32'h4600, 24'h700000, 0, 1'b0, last, errs);
    check("l7_burst_errs", 32'(errs), 32'd0);
    pulse_ls(10'd8, 32'h0);
    check_line("l7_contents", 24'h700000);
    read_pix(10'd2, v);
    check("l7_pix2", 32'(v), 32'h700002);

    // Abort in REQ (not accepted) with underrun_clr in the same cycle
    underrun_clr = 1'b1;
    pulse_ls(10'd9, 32'h0);
    underrun_clr = 1'b0;
    check("set_wins_underrun", 32'(underrun), 32'd1);
    check("l9_req", 32'(bus.mem_req), 32'd1);
    check("l9_addr", bus.mem_addr, 32'h5A00);
    check("pix_hold", 32'(bus.pix_data), 32'h700002);

    // Reset mid-burst
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) beat(24'h900000 + 24'(i));
    reset = 1'b1;
    #1;
    check("mid_rst_req", 32'(bus.mem_req), 32'd0);
    check("mid_rst_pix", 32'(bus.pix_data), 32'd0);
    check("mid_rst_underrun", 32'(underrun), 32'd0);
    check("mid_rst_addr", bus.mem_addr, 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) beat(24'h900003 + 24'(i));
    check("stray_no_req", 32'(bus.mem_req), 32'd0);
    pulse_ls(10'd1, 32'h0);
    check("l1_req", 32'(bus.mem_req), 32'd1);
    check("l1_addr", bus.mem_addr, 32'h0A00);
    fetch_line(32'h0A00, 24'h110000, 0, 1'b0, last, errs);
    check("l1_burst_errs", 32'(errs), 32'd0);
    pulse_ls(10'd2, 32'h0);
    read_pix(10'd5, v);
    check("l1_pix5", 32'(v), 32'h110005);
    read_pix(10'd639, v);
    check("l1_pix639", 32'(v), 32'h11027F);
    read_pix(10'd700, v);
    check("l1_pix700_oob", 32'(v), 32'd0);
    fetch_line(32'h1400, 24'h220000, 0, 1'b0, last, errs);
    check("l2_burst_errs", 32'(errs), 32'd0);

    // enable=0 gating and disabled line_start
    enable = 1'b0;
    read_pix(10'd5, v);
    check("dis_pix5", 32'(v), 32'd0);
    enable = 1'b1;
    read_pix(10'd5, v);
    check("reen_pix5", 32'(v), 32'h110005);
    enable = 1'b0;
    pulse_ls(10'd5, 32'h0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.mem_req !== 1'b0) cnt++;
      tick();
    end
    check("dis_no_req", 32'(cnt), 32'd0);
    cnt = 0;
    for (int x = 0; x < int'(H); x++) begin
      read_pix(10'(x), v);
      if (v !== 24'd0) cnt++;
    end
    check("dis_all_zero", 32'(cnt), 32'd0);
    enable = 1'b1;
    read_pix(10'd5, v);
    check("fills_cleared_pix5", 32'(v), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
